// File: rtl/pueo_trig_pkg.sv
// Shared constants for the PUEO multi-source trigger arbiter.
// Source numbering, frame phase points and the metadata marker bit.
package pueo_trig_pkg;

  localparam int SRC_SOFT = 0;
  localparam int SRC_PPS  = 1;
  localparam int SRC_EXT  = 2;
  localparam int SRC_RF   = 3;

  localparam int         FRAME_LEN     = 8;
  localparam logic [2:0] PHASE_GRANT   = 3'd2;
  localparam logic [2:0] PHASE_RELEASE = 3'd6;
  localparam logic [2:0] PHASE_LAST    = 3'(FRAME_LEN - 1);

  localparam logic META_MARK = 1'b1;

endpackage

// File: rtl/pueo_trig_rr_arb.sv
// Round-robin picker: lowest requesting index at or after the pointer.
// The pointer advances past the winner only when the caller commits the grant.
module pueo_trig_rr_arb #(
  parameter  int NCHAN = 4,
  localparam int SRC_W = $clog2(NCHAN)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [NCHAN-1:0] i_req,
  input  logic             i_adv,
  output logic [NCHAN-1:0] o_gnt,
  output logic [SRC_W-1:0] o_idx,
  output logic             o_any
);

  logic [SRC_W-1:0] r_ptr;
  logic [NCHAN-1:0] w_rot;
  logic [SRC_W-1:0] w_off;
  logic [SRC_W:0]   w_sum;

  // Rotate requests so the pointer lands on bit 0, then find the first set bit.
  assign w_rot = NCHAN'({i_req, i_req} >> r_ptr);

  always_comb begin
    w_off = '0;
    for (int k = NCHAN - 1; k >= 0; k--)
      if (w_rot[k]) w_off = SRC_W'(k);
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= (SRC_W+1)'(NCHAN)) w_sum = w_sum - (SRC_W+1)'(NCHAN);
  end

  assign o_any = |i_req;
  assign o_idx = w_sum[SRC_W-1:0];
  assign o_gnt = o_any ? (NCHAN'(1) << o_idx) : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_ptr <= '0;
    else if (i_adv && o_any)
      r_ptr <= (o_idx == SRC_W'(NCHAN - 1)) ? '0 : o_idx + 1'b1;
  end

endmodule

// File: rtl/pueo_trig_arbiter.sv
// Multi-source trigger arbiter: latches per-source requests, grants one per
// sysclk frame round-robin and presents the TURF trigger word for 4 clocks.
module pueo_trig_arbiter
  import pueo_trig_pkg::*;
#(
  parameter  int NCHAN     = 4,
  parameter  int ADDR_W    = 12,
  parameter  int HOLDOFF_W = 16,
  parameter  int DROP_W    = 16,
  localparam int SRC_W     = $clog2(NCHAN)
) (
  input  logic                 sysclk_i,
  input  logic                 sysclk_rst_i,
  input  logic                 sysclk_phase_i,
  input  logic                 running_i,
  input  logic [NCHAN-1:0]     trig_req_i,
  input  logic [NCHAN-1:0]     trig_mask_i,
  input  logic [ADDR_W-1:0]    cur_addr_i,
  input  logic [ADDR_W-1:0]    trig_offset_i,
  input  logic [HOLDOFF_W-1:0] holdoff_i,
  output logic [ADDR_W-1:0]    turf_trig_o,
  output logic [7:0]           turf_metadata_o,
  output logic [SRC_W-1:0]     turf_source_o,
  output logic                 turf_valid_o,
  output logic [DROP_W-1:0]    drop_count_o,
  output logic [NCHAN-1:0]     pending_o
);

  logic                               r_phase_act;
  logic [2:0]                         r_phase_cnt;
  logic [NCHAN-1:0]                   r_pend;
  logic [NCHAN-1:0][ADDR_W-1:0]       r_addr;
  logic [HOLDOFF_W-1:0]               r_hold;
  logic [DROP_W-1:0]                  r_drop;
  logic                               r_valid;
  logic [ADDR_W-1:0]                  r_trig;
  logic [SRC_W-1:0]                   r_src;
  logic [6:0]                         r_evcnt;

  logic                               w_grant_cyc;
  logic                               w_grant;
  logic [NCHAN-1:0]                   w_gnt;
  logic [NCHAN-1:0]                   w_gnt_clr;
  logic [SRC_W-1:0]                   w_gidx;
  logic                               w_gany;
  logic                               w_busy;
  logic [NCHAN-1:0]                   w_acc;
  logic [NCHAN-1:0]                   w_drop;
  logic [3:0]                         w_ndrop;
  logic [DROP_W:0]                    w_dsum;
  logic                               w_vclr;

  assign w_grant_cyc = r_phase_act && (r_phase_cnt == PHASE_GRANT);
  assign w_grant     = w_grant_cyc && w_gany;
  assign w_gnt_clr   = w_grant_cyc ? w_gnt : '0;

  pueo_trig_rr_arb #(.NCHAN(NCHAN)) u_arb (
    .i_clk (sysclk_i),
    .i_rst (sysclk_rst_i),
    .i_req (r_pend),
    .i_adv (w_grant_cyc),
    .o_gnt (w_gnt),
    .o_idx (w_gidx),
    .o_any (w_gany)
  );

  // A source being granted this cycle counts as free, so a same-cycle request is fresh.
  assign w_busy = !running_i || (r_hold != '0);
  assign w_acc  = trig_req_i & ~trig_mask_i & ~(r_pend & ~w_gnt_clr) & {NCHAN{!w_busy}};
  assign w_drop = trig_req_i & ~trig_mask_i & ~w_acc;

  always_comb begin
    w_ndrop = '0;
    for (int i = 0; i < NCHAN; i++) w_ndrop = w_ndrop + 4'(w_drop[i]);
  end

  assign w_dsum = {1'b0, r_drop} + (DROP_W+1)'(w_ndrop);
  assign w_vclr = r_valid && ((r_phase_act && r_phase_cnt == PHASE_RELEASE) || sysclk_phase_i);

  always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
    if (sysclk_rst_i) begin
      r_phase_act <= 1'b0;
      r_phase_cnt <= '0;
    end else if (sysclk_phase_i) begin
      r_phase_act <= 1'b1;
      r_phase_cnt <= '0;
    end else if (r_phase_act && r_phase_cnt != PHASE_LAST) begin
      r_phase_cnt <= r_phase_cnt + 3'd1;
    end
  end

  always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
    if (sysclk_rst_i) begin
      r_pend <= '0;
      r_addr <= '0;
      r_drop <= '0;
      r_hold <= '0;
    end else begin
      r_pend <= (r_pend & ~w_gnt_clr) | w_acc;
      for (int i = 0; i < NCHAN; i++)
        if (w_acc[i]) r_addr[i] <= cur_addr_i;
      r_drop <= w_dsum[DROP_W] ? '1 : w_dsum[DROP_W-1:0];
      if (w_grant)
        r_hold <= holdoff_i;
      else if (r_hold != '0)
        r_hold <= r_hold - 1'b1;
    end
  end

  always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
    if (sysclk_rst_i) begin
      r_valid <= 1'b0;
      r_trig  <= '0;
      r_src   <= '0;
      r_evcnt <= '0;
    end else if (w_grant) begin
      r_valid <= 1'b1;
      r_trig  <= r_addr[w_gidx] - trig_offset_i;
      r_src   <= w_gidx;
    end else if (w_vclr) begin
      r_valid <= 1'b0;
      r_evcnt <= r_evcnt + 7'd1;
    end
  end

  assign turf_trig_o     = r_trig;
  assign turf_metadata_o = {META_MARK, r_evcnt};
  assign turf_source_o   = r_src;
  assign turf_valid_o    = r_valid;
  assign drop_count_o    = r_drop;
  assign pending_o       = r_pend;

endmodule

// File: tb/tb_pueo_trig_arbiter.sv
// Directed bench for pueo_trig_arbiter: inputs driven and outputs sampled on the
// falling edge; one frame = phase pulse followed by 8 observed cycles.
module tb_pueo_trig_arbiter;

  logic        clk, rst, phase, running;
  logic [3:0]  req, mask, pend;
  logic [11:0] cur, off, trig;
  logic [15:0] hold, drop;
  logic [7:0]  meta;
  logic [1:0]  src;
  logic        valid;

  int nchk = 0;
  int npass = 0;

  logic [7:0]  vm;
  logic [11:0] ft;
  logic [1:0]  fs;
  logic [7:0]  fm;
  int          bad;

  pueo_trig_arbiter #(.NCHAN(4), .ADDR_W(12), .HOLDOFF_W(16), .DROP_W(16)) dut (
    .sysclk_i        (clk),
    .sysclk_rst_i    (rst),
    .sysclk_phase_i  (phase),
    .running_i       (running),
    .trig_req_i      (req),
    .trig_mask_i     (mask),
    .cur_addr_i      (cur),
    .trig_offset_i   (off),
    .holdoff_i       (hold),
    .turf_trig_o     (trig),
    .turf_metadata_o (meta),
    .turf_source_o   (src),
    .turf_valid_o    (valid),
    .drop_count_o    (drop),
    .pending_o       (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_req(input logic [3:0] r);
    req = r;
    @(negedge clk);
    req = '0;
  endtask

  // Phase pulse then 8 cycles; bit k of v is turf_valid_o while phase count == k.
  task automatic frame(output logic [7:0] v, output logic [11:0] t,
                       output logic [1:0] s, output logic [7:0] m);
    v = '0; t = '0; s = '0; m = '0;
    phase = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      phase = 1'b0;
      v[k] = valid;
      if (valid) begin t = trig; s = src; m = meta; end
    end
  endtask

  initial begin
    rst = 1'b1; phase = 1'b0; running = 1'b0; req = '0; mask = '0;
    cur = '0; off = '0; hold = '0;
    cyc(2);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_meta",  32'(meta),  32'h80);
    chk("rst_trig",  32'(trig),  32'h0);
    chk("rst_src",   32'(src),   32'h0);
    chk("rst_drop",  32'(drop),  32'h0);
    chk("rst_pend",  32'(pend),  32'h0);
    rst = 1'b0;
    cyc(2);

    // basic soft trigger with offset
    running = 1'b1; cur = 12'h123; off = 12'h010;
    pulse_req(4'b0001);
    chk("t1_pend", 32'(pend), 32'h1);
    frame(vm, ft, fs, fm);
    chk("t1_window", 32'(vm), 32'h78);
    chk("t1_trig",   32'(ft), 32'h113);
    chk("t1_src",    32'(fs), 32'h0);
    chk("t1_meta",   32'(fm), 32'h80);
    chk("t1_pend_clr", 32'(pend), 32'h0);

    // two simultaneous requests served in consecutive frames
    cur = 12'h200; off = 12'h000;
    pulse_req(4'b1010);
    chk("t2_pend", 32'(pend), 32'ha);
    frame(vm, ft, fs, fm);
    chk("t2a_src",  32'(fs), 32'h1);
    chk("t2a_trig", 32'(ft), 32'h200);
    chk("t2a_meta", 32'(fm), 32'h81);
    chk("t2a_pend", 32'(pend), 32'h8);
    frame(vm, ft, fs, fm);
    chk("t2b_window", 32'(vm), 32'h78);
    chk("t2b_src",    32'(fs), 32'h3);
    chk("t2b_meta",   32'(fm), 32'h82);
    chk("t2_drop",    32'(drop), 32'h0);

    // holdoff: request 10 clocks after the grant is dropped
    hold = 16'd20; cur = 12'h050;
    pulse_req(4'b0100);
    frame(vm, ft, fs, fm);
    hold = 16'd0;
    chk("t3_src",  32'(fs), 32'h2);
    chk("t3_trig", 32'(ft), 32'h050);
    chk("t3_meta", 32'(fm), 32'h83);
    cyc(5);
    pulse_req(4'b0001);
    chk("t3_drop", 32'(drop), 32'h1);
    chk("t3_pend", 32'(pend), 32'h0);
    frame(vm, ft, fs, fm);
    chk("t3_no_valid", 32'(vm), 32'h0);
    cyc(20);

    // masked request ignored, not-running request counted
    mask = 4'b0001;
    pulse_req(4'b0001);
    chk("t4_mask_drop", 32'(drop), 32'h1);
    chk("t4_mask_pend", 32'(pend), 32'h0);
    mask = 4'b0000; running = 1'b0;
    pulse_req(4'b0010);
    chk("t4_run_drop", 32'(drop), 32'h2);
    chk("t4_run_pend", 32'(pend), 32'h0);
    running = 1'b1;

    // address underflow wraps modulo 2^12
    off = 12'h005; cur = 12'h002;
    pulse_req(4'b1000);
    frame(vm, ft, fs, fm);
    chk("t5_trig", 32'(ft), 32'hffd);
    chk("t5_src",  32'(fs), 32'h3);
    chk("t5_meta", 32'(fm), 32'h84);

    // drive event count to 127, then observe the 7-bit wrap
    bad = 0;
    for (int i = 0; i < 122; i++) begin
      pulse_req(4'b0001);
      frame(vm, ft, fs, fm);
      if (vm !== 8'h78 || fm !== 8'(8'h85 + i)) bad++;
    end
    chk("t5_loop_bad", 32'(bad), 32'h0);
    pulse_req(4'b0001);
    frame(vm, ft, fs, fm);
    chk("t5_meta_ff", 32'(fm), 32'hff);
    pulse_req(4'b0001);
    frame(vm, ft, fs, fm);
    chk("t5_meta_wrap", 32'(fm), 32'h80);

    // phase pulse mid-window aborts the word but still counts it
    pulse_req(4'b0010);
    phase = 1'b1;
    cyc(1); phase = 1'b0;
    cyc(3);
    chk("t6_valid_on", 32'(valid), 32'h1);
    chk("t6_src",      32'(src),   32'h1);
    chk("t6_meta",     32'(meta),  32'h81);
    phase = 1'b1;
    cyc(1); phase = 1'b0;
    chk("t6_valid_abort", 32'(valid), 32'h0);
    chk("t6_meta_inc",    32'(meta),  32'h82);
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (valid !== 1'b0) bad++;
    end
    chk("t6_no_regrant", 32'(bad), 32'h0);

    // async reset in the middle of a valid window, with another source pending
    pulse_req(4'b0100);
    phase = 1'b1;
    cyc(1); phase = 1'b0;
    pulse_req(4'b0010);
    cyc(2);
    chk("t7_valid_on", 32'(valid), 32'h1);
    chk("t7_src",      32'(src),   32'h2);
    chk("t7_pend",     32'(pend),  32'h2);
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_valid", 32'(valid), 32'h0);
    chk("t7_rst_meta",  32'(meta),  32'h80);
    chk("t7_rst_drop",  32'(drop),  32'h0);
    chk("t7_rst_pend",  32'(pend),  32'h0);
    chk("t7_rst_trig",  32'(trig),  32'h0);
    cyc(2);
    rst = 1'b0;
    frame(vm, ft, fs, fm);
    chk("t7_no_grant", 32'(vm), 32'h0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
